// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter with a small TX FIFO on the core data bus.
// Optional macro UART_TX_IRQ_EN adds the CTRL irq_enable bit and the irq_o output.
//
// state | meaning
// IDLE  | line high, waiting for a byte in the FIFO
// START | start bit (line low) for DIV cycles
// DATA  | 8 data bits, LSB first, DIV cycles each
// STOP  | stop bit (line high) for DIV cycles; chains to START if FIFO non-empty

module uart_tx_mmio #(
    parameter int unsigned CLK_FREQ   = 1000000,
    parameter int unsigned BAUD_RATE  = 100000,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en_i,
    input  logic        wr_en_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        ack_o,
    output logic        tx_o
`ifdef UART_TX_IRQ_EN
    ,
    output logic        irq_o
`endif
);

    localparam int unsigned DIV = CLK_FREQ / BAUD_RATE;
    localparam int unsigned AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW  = AW + 1;
    localparam int unsigned DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    generate
        if (DIV < 2) begin : g_bad_div
            $error("uart_tx_mmio: CLK_FREQ/BAUD_RATE must be >= 2");
        end
        if (BASE_ADDR[3:0] != 4'h0) begin : g_bad_base
            $error("uart_tx_mmio: BASE_ADDR[3:0] must be 0");
        end
        if (FIFO_DEPTH < 2 || FIFO_DEPTH > 256 ||
            (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("uart_tx_mmio: FIFO_DEPTH must be a power of two in 2..256");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [DW-1:0]   div_q, div_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d;

    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            ovf_q, ovf_d;
    logic            ack_q, ack_d;
    logic [31:0]     rdata_q, rdata_d;

    logic            sel, acc, wr_acc, rd_acc;
    logic [1:0]      off;
    logic            full, empty, busy;
    logic            push_req, push, pop;
    logic [31:0]     status, ctrl_rd;

    logic            unused_bits;
    assign unused_bits = ^{data_i[31:8], addr_i[1:0]};

    assign sel    = (addr_i[31:4] == BASE_ADDR[31:4]);
    assign acc    = sel & (rd_en_i | wr_en_i);
    assign wr_acc = sel & wr_en_i;
    assign rd_acc = sel & rd_en_i & ~wr_en_i;
    assign off    = addr_i[3:2];

    assign full  = (count_q == CW'(FIFO_DEPTH));
    assign empty = (count_q == '0);
    assign busy  = (state_q != ST_IDLE);

    // Full is taken from the registered count, so a same-cycle pop never rescues a push.
    assign push_req = wr_acc & (off == 2'd0);
    assign push     = push_req & ~full;

    assign status = {16'h0, 8'(count_q), 4'h0, ovf_q, busy, empty, full};

`ifdef UART_TX_IRQ_EN
    logic irq_en_q, irq_en_d;
    logic irq_q, irq_d;

    assign ctrl_rd = {31'h0, irq_en_q};
    assign irq_o   = irq_q;

    always_comb begin
        irq_en_d = irq_en_q;
        if (wr_acc && off == 2'd2) begin
            irq_en_d = data_i[0];
        end
        irq_d = irq_en_q & empty & ~busy;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
            irq_q    <= irq_d;
        end
    end
`else
    assign ctrl_rd = 32'h0;
`endif

    always_comb begin
        ack_d   = acc;
        rdata_d = 32'h0;
        if (rd_acc) begin
            case (off)
                2'd1:    rdata_d = status;
                2'd2:    rdata_d = ctrl_rd;
                default: rdata_d = 32'h0;
            endcase
        end

        ovf_d = ovf_q;
        if (push_req && full) begin
            ovf_d = 1'b1;
        end else if (wr_acc && off == 2'd1 && data_i[3]) begin
            ovf_d = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!empty) begin
                    state_d = ST_START;
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    div_d   = DIV_LAST;
                end
            end
            ST_START: begin
                if (div_q == '0) begin
                    state_d = ST_DATA;
                    div_d   = DIV_LAST;
                    bit_d   = 3'd0;
                end else begin
                    div_d = div_q - DW'(1);
                end
            end
            ST_DATA: begin
                if (div_q == '0) begin
                    div_d   = DIV_LAST;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    div_d = div_q - DW'(1);
                end
            end
            ST_STOP: begin
                if (div_q == '0) begin
                    if (!empty) begin
                        state_d = ST_START;
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        div_d   = DIV_LAST;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    div_d = div_q - DW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Line level is registered from the next state so tx_o is glitch-free.
        case (state_d)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shift_d[0];
            default:  tx_d = 1'b1;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= data_i[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            div_q    <= '0;
            bit_q    <= 3'd0;
            shift_q  <= 8'h0;
            tx_q     <= 1'b1;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            ack_q    <= 1'b0;
            rdata_q  <= 32'h0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            ack_q    <= ack_d;
            rdata_q  <= rdata_d;
        end
    end

    assign ack_o  = ack_q;
    assign data_o = rdata_q;
    assign tx_o   = tx_q;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio (DIV=10, FIFO_DEPTH=8): register table plus frame sequences.

module tb_uart_tx_mmio;

    localparam int DIV = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_en, wr_en;
    logic [31:0] addr, wdata;
    logic [31:0] data_o;
    logic        ack_o, tx_o;
`ifdef UART_TX_IRQ_EN
    logic        irq_o;
`endif

    uart_tx_mmio #(
        .CLK_FREQ   (1000000),
        .BAUD_RATE  (100000),
        .BASE_ADDR  (32'h0000_1000),
        .FIFO_DEPTH (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .rd_en_i (rd_en),
        .wr_en_i (wr_en),
        .addr_i  (addr),
        .data_i  (wdata),
        .data_o  (data_o),
        .ack_o   (ack_o),
        .tx_o    (tx_o)
`ifdef UART_TX_IRQ_EN
        ,
        .irq_o   (irq_o)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_ack;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // One bus request, accepted on the next edge; returns ack/data of the following cycle.
    task automatic bus_op(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, output logic ack, output logic [31:0] q);
        rd_en = rd;
        wr_en = wr;
        addr  = a;
        wdata = d;
        @(posedge clk);
        #1;
        rd_en = 1'b0;
        wr_en = 1'b0;
        addr  = 32'h0;
        wdata = 32'h0;
        ack   = ack_o;
        q     = data_o;
    endtask

    task automatic wr_chk(input logic [31:0] a, input logic [31:0] d, input string name);
        logic        ack;
        logic [31:0] q;
        bus_op(1'b0, 1'b1, a, d, ack, q);
        chk({name, " ack"}, {31'h0, ack}, 32'h1);
    endtask

    task automatic rd_chk(input logic [31:0] a, input logic [31:0] exp, input string name);
        logic        ack;
        logic [31:0] q;
        bus_op(1'b1, 1'b0, a, 32'h0, ack, q);
        chk({name, " ack"}, {31'h0, ack}, 32'h1);
        chk({name, " data"}, q, exp);
    endtask

    // Entered just after the edge on which START was entered (offset start_c cycles in).
    // Optionally issues a STATUS read accepted on the frame's final edge.
    task automatic check_frame(input logic [7:0] b, input int start_c, input bit rd_last,
                               input string name);
        int   bad [10];
        logic exp;
        int   k;
        for (int i = 0; i < 10; i++) bad[i] = 0;
        for (int c = start_c; c < 10 * DIV; c++) begin
            k = c / DIV;
            if (k == 0)      exp = 1'b0;
            else if (k == 9) exp = 1'b1;
            else             exp = b[k-1];
            if (tx_o !== exp) bad[k]++;
            if (rd_last && c == 10 * DIV - 1) begin
                rd_en = 1'b1;
                addr  = 32'h0000_1004;
            end
            @(posedge clk);
            #1;
        end
        rd_en = 1'b0;
        addr  = 32'h0;
        for (int i = 0; i < 10; i++)
            chk($sformatf("%s bit%0d bad cycles", name, i), bad[i], 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic        ack;
        logic [31:0] q;
        int          bad;

        vecs[0]  = '{1'b1, 1'b0, 32'h0000_1004, 32'h0,  1'b1, 32'h2};
        vecs[1]  = '{1'b1, 1'b0, 32'h0000_1000, 32'h0,  1'b1, 32'h0};
        vecs[2]  = '{1'b1, 1'b0, 32'h0000_1008, 32'h0,  1'b1, 32'h0};
        vecs[3]  = '{1'b1, 1'b0, 32'h0000_100C, 32'h0,  1'b1, 32'h0};
        vecs[4]  = '{1'b0, 1'b1, 32'h0000_100C, 32'hFF, 1'b1, 32'h0};
        vecs[5]  = '{1'b1, 1'b0, 32'h0000_2004, 32'h0,  1'b0, 32'h0};
        vecs[6]  = '{1'b0, 1'b1, 32'h0000_2000, 32'hAA, 1'b0, 32'h0};
        vecs[7]  = '{1'b0, 1'b1, 32'h0000_1010, 32'h41, 1'b0, 32'h0};
        vecs[8]  = '{1'b1, 1'b0, 32'h0000_0FFC, 32'h0,  1'b0, 32'h0};
        vecs[9]  = '{1'b1, 1'b1, 32'h0000_1004, 32'h0,  1'b1, 32'h0};
        vecs[10] = '{1'b0, 1'b1, 32'h0000_1008, 32'h0,  1'b1, 32'h0};
        vecs[11] = '{1'b1, 1'b0, 32'h0000_1004, 32'h0,  1'b1, 32'h2};
        vecs[12] = '{1'b1, 1'b0, 32'h0000_1006, 32'h0,  1'b1, 32'h2};

        rst   = 1'b1;
        rd_en = 1'b0;
        wr_en = 1'b0;
        addr  = 32'h0;
        wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("reset tx_o", {31'h0, tx_o}, 32'h1);
        chk("reset ack_o", {31'h0, ack_o}, 32'h0);
        chk("reset data_o", data_o, 32'h0);

        bad = 0;
        repeat (50) begin
            @(posedge clk);
            #1;
            if (tx_o !== 1'b1 || ack_o !== 1'b0) bad++;
        end
        chk("idle 50 cycles bad", bad, 0);

        for (int i = 0; i < 13; i++) begin
            bus_op(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, ack, q);
            chk($sformatf("vec%0d ack", i), {31'h0, ack}, {31'h0, vecs[i].exp_ack});
            chk($sformatf("vec%0d data", i), q, vecs[i].exp_data);
        end

        rd_chk(32'h0000_1004, 32'h2, "status pre");
        @(posedge clk);
        #1;
        chk("ack one cycle only", {31'h0, ack_o}, 32'h0);
        chk("data_o zero w/o ack", data_o, 32'h0);

        // Single byte 0x55
        wr_chk(32'h0000_1000, 32'h55, "wr 55");
        chk("tx high on accept", {31'h0, tx_o}, 32'h1);
        @(posedge clk);
        #1;
        check_frame(8'h55, 0, 1'b1, "f55");
        chk("f55 last-stop ack", {31'h0, ack_o}, 32'h1);
        chk("f55 busy in last stop", data_o, 32'h6);
        rd_chk(32'h0000_1004, 32'h2, "f55 status after");

        // Three back-to-back bytes, no idle gap between frames
        wr_chk(32'h0000_1000, 32'h01, "wr 01");
        wr_chk(32'h0000_1000, 32'h02, "wr 02");
        wr_chk(32'h0000_1000, 32'h03, "wr 03");
        rd_chk(32'h0000_1004, 32'h204, "b2b status count 2");
        check_frame(8'h01, 2, 1'b0, "f01");
        check_frame(8'h02, 0, 1'b0, "f02");
        check_frame(8'h03, 0, 1'b1, "f03");
        chk("f03 last-stop ack", {31'h0, ack_o}, 32'h1);
        chk("f03 busy in last stop", data_o, 32'h6);
        rd_chk(32'h0000_1004, 32'h2, "b2b status after");

        // Overflow: first byte popped, 8 buffered, 10th write dropped
        for (int i = 0; i < 10; i++)
            wr_chk(32'h0000_1000, 32'hA0 + i, $sformatf("ovf wr%0d", i));
        rd_chk(32'h0000_1004, 32'h80D, "ovf status");
        wr_chk(32'h0000_1004, 32'h8, "ovf clear");
        rd_chk(32'h0000_1004, 32'h805, "ovf cleared status");
        repeat (89) begin
            @(posedge clk);
            #1;
        end
        for (int i = 1; i <= 8; i++)
            check_frame(8'hA0 + 8'(i), 0, (i == 8), $sformatf("fA%0d", i));
        chk("ovf last-stop ack", {31'h0, ack_o}, 32'h1);
        chk("ovf busy in last stop", data_o, 32'h6);
        rd_chk(32'h0000_1004, 32'h2, "ovf drained status");

        // Reset in the middle of DATA
        wr_chk(32'h0000_1000, 32'h00, "rst wr0");
        wr_chk(32'h0000_1000, 32'h99, "rst wr1");
        repeat (35) begin
            @(posedge clk);
            #1;
        end
        chk("tx low mid data", {31'h0, tx_o}, 32'h0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("tx high after reset", {31'h0, tx_o}, 32'h1);
        bad = 0;
        repeat (300) begin
            @(posedge clk);
            #1;
            if (tx_o !== 1'b1) bad++;
        end
        chk("no frame after reset", bad, 0);
        rd_chk(32'h0000_1004, 32'h2, "status after reset");

`ifdef UART_TX_IRQ_EN
        wr_chk(32'h0000_1008, 32'h1, "irq enable");
        rd_chk(32'h0000_1008, 32'h1, "ctrl readback");
        chk("irq idle", {31'h0, irq_o}, 32'h1);
        wr_chk(32'h0000_1000, 32'h0F, "irq wr");
        @(posedge clk);
        #1;
        bad = 0;
        for (int c = 0; c <= 10 * DIV; c++) begin
            if (irq_o !== 1'b0) bad++;
            @(posedge clk);
            #1;
        end
        chk("irq low during frame", bad, 0);
        chk("irq after busy clears", {31'h0, irq_o}, 32'h1);
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
